// File: rtl/updown_counter_if.sv
// updown_counter_if: control/status bundle between a counter user (master) and the counter (slave)
interface updown_counter_if #(parameter int WIDTH = 8);
  logic             enable;
  logic             up_down;
  logic             mode;
  logic             load;
  logic [WIDTH-1:0] load_value;
  logic             clear_ovf;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             ovf;
  modport master (
    output enable, up_down, mode, load, load_value, clear_ovf,
    input  count, tc, ovf
  );
  modport slave (
    input  enable, up_down, mode, load, load_value, clear_ovf,
    output count, tc, ovf
  );
endinterface

// File: rtl/updown_counter.sv
// updown_counter: modulus up/down counter with load, wrap/saturate, tc pulse and sticky ovf; COUNTER_PRESCALE_EN adds a step prescaler
module updown_counter #(
  parameter int WIDTH     = 8,
  parameter int MAX_VALUE = (1 << WIDTH) - 1,
  parameter int PRESCALE  = 4
) (
  input logic clk,
  input logic reset,
  updown_counter_if.slave bus
);
  localparam logic [WIDTH-1:0] MAXV = WIDTH'(MAX_VALUE);
  if (WIDTH < 2 || MAX_VALUE < 1 || longint'(MAX_VALUE) >= (longint'(1) << WIDTH) || PRESCALE < 2) begin : g_bad_params
    $error("updown_counter: illegal parameters");
  end
  logic [WIDTH-1:0] count_q, nxt, load_clip;
  logic             tc_q, ovf_q, step, at_lim, limit;
`ifdef COUNTER_PRESCALE_EN
  localparam int PW = $clog2(PRESCALE);
  localparam logic [PW-1:0] PLAST = PW'(PRESCALE - 1);
  logic [PW-1:0] pre_q;
  assign step = bus.enable && pre_q == PLAST;
  always_ff @(posedge clk or negedge reset)
    if (!reset) pre_q <= '0;
    else if (bus.load) pre_q <= '0;
    else if (bus.enable) pre_q <= step ? '0 : pre_q + 1'b1;
`else
  assign step = bus.enable;
`endif
  always_comb begin
    at_lim    = bus.up_down ? count_q == MAXV : count_q == '0;
    nxt       = bus.up_down ? (at_lim ? (bus.mode ? MAXV : '0) : count_q + 1'b1)
                            : (at_lim ? (bus.mode ? '0 : MAXV) : count_q - 1'b1);
    limit     = step && at_lim && !bus.load;
    load_clip = bus.load_value > MAXV ? MAXV : bus.load_value;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      count_q <= '0;
      tc_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= bus.load ? load_clip : step ? nxt : count_q;
      tc_q    <= limit;
      ovf_q   <= limit || (ovf_q && !bus.clear_ovf);
    end
  assign bus.count = count_q;
  assign bus.tc    = tc_q;
  assign bus.ovf   = ovf_q;
endmodule

// File: tb/tb_updown_counter.sv
// tb_updown_counter: directed checks for updown_counter at WIDTH=4, MAX_VALUE=9 (prescaler run when COUNTER_PRESCALE_EN is defined)
module tb_updown_counter;
  localparam int W = 4, MV = 9;
  logic clk = 1'b0, reset = 1'b0;
  int n_cmp = 0, n_bad = 0;
  updown_counter_if #(.WIDTH(W)) bus();
  updown_counter #(.WIDTH(W), .MAX_VALUE(MV), .PRESCALE(4)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic en, ud, md, ld, input logic [W-1:0] lv, input logic co);
    bus.enable = en; bus.up_down = ud; bus.mode = md; bus.load = ld; bus.load_value = lv; bus.clear_ovf = co;
  endtask
  task automatic expect_all(input string tag, input int c, input int t, input int o);
    check({tag, ".count"}, 32'(bus.count), c);
    check({tag, ".tc"}, 32'(bus.tc), t);
    check({tag, ".ovf"}, 32'(bus.ovf), o);
  endtask
  initial begin
    drive(0, 0, 0, 0, 0, 0);
    #1;
    expect_all("reset", 0, 0, 0);
    tick;
    reset = 1'b1;
`ifndef COUNTER_PRESCALE_EN
    begin
      int cnt_exp [12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
      int tc_exp [12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0};
      drive(1, 1, 0, 0, 0, 0);
      for (int i = 0; i < 12; i++) begin
        tick;
        check($sformatf("wrap_up[%0d].count", i), 32'(bus.count), cnt_exp[i]);
        check($sformatf("wrap_up[%0d].tc", i), 32'(bus.tc), tc_exp[i]);
      end
      check("wrap_up.ovf", 32'(bus.ovf), 1);
    end
    drive(1, 1, 0, 1, 3, 1);
    tick;
    expect_all("load3_clr", 3, 0, 0);
    begin
      int cnt_exp [5] = '{2, 1, 0, 0, 0};
      int tc_exp [5] = '{0, 0, 0, 1, 1};
      drive(1, 0, 1, 0, 0, 0);
      for (int i = 0; i < 5; i++) begin
        tick;
        check($sformatf("sat_dn[%0d].count", i), 32'(bus.count), cnt_exp[i]);
        check($sformatf("sat_dn[%0d].tc", i), 32'(bus.tc), tc_exp[i]);
      end
      check("sat_dn.ovf", 32'(bus.ovf), 1);
    end
    drive(0, 0, 1, 0, 0, 0);
    tick;
    expect_all("hold", 0, 0, 1);
    drive(0, 1, 0, 1, 15, 0);
    tick;
    expect_all("load15", 9, 0, 1);
    drive(1, 1, 0, 1, 9, 0);
    tick;
    expect_all("load_beats_step", 9, 0, 1);
    drive(1, 1, 1, 0, 0, 0);
    tick;
    expect_all("sat_up_top", 9, 1, 1);
    drive(1, 0, 1, 0, 0, 1);
    tick;
    expect_all("clr_nonlimit", 8, 0, 0);
    drive(0, 0, 1, 1, 0, 0);
    tick;
    expect_all("load0", 0, 0, 0);
    drive(1, 0, 1, 0, 0, 1);
    tick;
    expect_all("clr_vs_limit", 0, 1, 1);
    drive(1, 0, 0, 0, 0, 0);
    tick;
    expect_all("wrap_dn", 9, 1, 1);
    tick;
    expect_all("wrap_dn_next", 8, 0, 1);
    drive(0, 1, 0, 1, 6, 0);
    tick;
    expect_all("load6", 6, 0, 1);
    #3;
    reset = 1'b0;
    #1;
    expect_all("async_reset", 0, 0, 0);
    drive(1, 1, 0, 0, 0, 0);
    #2;
    reset = 1'b1;
    tick;
    expect_all("after_reset", 1, 0, 0);
`else
    drive(1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 12; i++) begin
      tick;
      check($sformatf("pre[%0d].count", i), 32'(bus.count), (i + 1) / 4);
      check($sformatf("pre[%0d].tc", i), 32'(bus.tc), 0);
    end
    drive(0, 1, 0, 0, 0, 0);
    tick;
    tick;
    check("pre_stall.count", 32'(bus.count), 3);
    begin
      int cnt_exp [4] = '{3, 3, 3, 4};
      drive(1, 1, 0, 0, 0, 0);
      for (int i = 0; i < 4; i++) begin
        tick;
        check($sformatf("pre_resume[%0d].count", i), 32'(bus.count), cnt_exp[i]);
      end
    end
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
